// File: rtl/load_store_unit.sv
// load_store_unit: data-port initiator with alignment, lane steering and load extension; LSU_TIMEOUT_EN adds a REQ wait limit.
module load_store_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [4:0]            req_tag,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic [4:0]            resp_tag,
    output logic                  resp_misaligned,
    output logic                  resp_timeout,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_write_data,
    output logic                  dmem_read,
    output logic                  dmem_write,
    output logic [3:0]            dmem_byte_enable,
    input  logic [DATA_WIDTH-1:0] dmem_read_data,
    input  logic                  dmem_ready
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t state, state_nx;
    logic                  store_q, uns_q, accept, misaligned, to_hit;
    logic [1:0]            size_q, off_q;
    logic [4:0]            tag_q;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] wdata_rep, shifted, load_data;

    assign req_ready  = state == IDLE;
    assign resp_valid = state == DONE;
    assign dmem_read  = state == REQ && !store_q;
    assign dmem_write = state == REQ && store_q;
    assign accept     = req_valid && req_ready;
    assign misaligned = (req_size == 2'b01 && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'b00);
    assign be = !req_store ? 4'b0000 :
                req_size == 2'b00 ? 4'b0001 << req_addr[1:0] :
                req_size == 2'b01 ? 4'b0011 << req_addr[1:0] : 4'b1111;
    assign wdata_rep = req_size == 2'b00 ? {4{req_wdata[7:0]}} :
                       req_size == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
    assign shifted   = dmem_read_data >> {off_q, 3'b000};
    assign load_data = size_q == 2'b00 ? {{24{~uns_q & shifted[7]}}, shifted[7:0]} :
                       size_q == 2'b01 ? {{16{~uns_q & shifted[15]}}, shifted[15:0]} : shifted;

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (state != REQ)
            cnt <= '0;
        else if (!dmem_ready)
            cnt <= cnt + CW'(1);
    end
    // Fires on the last permitted REQ cycle; a coincident ready still completes normally.
    assign to_hit = state == REQ && !dmem_ready && cnt == CW'(TIMEOUT_CYCLES - 1);
`else
    assign to_hit = TIMEOUT_CYCLES < 0;
`endif

    always_comb begin
        state_nx = state;
        if (state == IDLE && accept)
            state_nx = misaligned ? DONE : REQ;
        else if (state == REQ && (dmem_ready || to_hit))
            state_nx = DONE;
        else if (state == DONE)
            state_nx = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            store_q          <= 1'b0;
            uns_q            <= 1'b0;
            size_q           <= 2'b00;
            off_q            <= 2'b00;
            tag_q            <= '0;
            resp_data        <= '0;
            resp_tag         <= '0;
            resp_misaligned  <= 1'b0;
            resp_timeout     <= 1'b0;
            dmem_addr        <= '0;
            dmem_write_data  <= '0;
            dmem_byte_enable <= 4'b0000;
        end else begin
            state <= state_nx;
            if (state == IDLE && accept) begin
                store_q          <= req_store;
                uns_q            <= req_unsigned;
                size_q           <= req_size;
                off_q            <= req_addr[1:0];
                tag_q            <= req_tag;
                dmem_addr        <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                dmem_write_data  <= wdata_rep;
                dmem_byte_enable <= be;
                // Misaligned ops complete straight from IDLE, so the response is loaded here.
                if (misaligned) begin
                    resp_data       <= '0;
                    resp_tag        <= req_tag;
                    resp_misaligned <= 1'b1;
                    resp_timeout    <= 1'b0;
                end
            end else if (state == REQ && (dmem_ready || to_hit)) begin
                resp_data       <= (store_q || !dmem_ready) ? '0 : load_data;
                resp_tag        <= tag_q;
                resp_misaligned <= 1'b0;
                resp_timeout    <= !dmem_ready;
            end
        end
    end
endmodule
